// File: rtl/axi_lite_cmd_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM encoding,
// AXI response codes and the fixed protection attribute.
package axi_lite_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

  // States in which the master waits on the slave and the watchdog runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WR_AW_W) || (s == ST_WR_B) || (s == ST_RD_AR) || (s == ST_RD_R);
  endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Saturating cycle counter with clear/enable; raises a sticky flag once the
// count reaches C_TIMEOUT_CYCLES. A value of 0 disables the flag.
module axi_lite_watchdog #(
  parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic timeout_err
);

  localparam int unsigned CNT_W = (C_TIMEOUT_CYCLES < 2) ? 1 : $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_TIMEOUT_CYCLES);
  localparam logic ENABLED = (C_TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // The flag is set on the edge where the count first reaches the limit.
    if (ENABLED && en && !clr && (cnt_d == CNT_MAX)) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_err = flag_q;

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master turning register commands into AXI
// write/read transactions and returning the result on a response channel.
//   state      | meaning
//   ST_IDLE    | cmd_ready high, waiting for a command
//   ST_WR_AW_W | AW and W offered, each retired by its own handshake
//   ST_WR_B    | BREADY high, waiting for the write response
//   ST_RD_AR   | ARVALID high, waiting for ARREADY
//   ST_RD_R    | RREADY high, waiting for read data
//   ST_RSP     | rsp_valid high with a stable payload until rsp_ready
module axi_lite_cmd_master
  import axi_lite_cmd_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            write_q, write_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // All VALID/READY outputs come from registered state only.
  assign M_AXI_AWVALID = (state_q == ST_WR_AW_W) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == ST_WR_AW_W) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == ST_WR_B);
  assign M_AXI_ARVALID = (state_q == ST_RD_AR);
  assign M_AXI_RREADY  = (state_q == ST_RD_R);

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = AXPROT_DEFAULT;
  assign M_AXI_ARPROT = AXPROT_DEFAULT;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY  && M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY  && M_AXI_RVALID;

  assign cmd_ready = (state_q == ST_IDLE) && !M_AXI_ARESET;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_write = rsp_valid && write_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_resp  = rsp_valid ? resp_q : RESP_OKAY;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = RESP_OKAY;
          state_d   = cmd_write ? ST_WR_AW_W : ST_RD_AR;
        end
      end
      ST_WR_AW_W: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (b_hs) begin
          resp_d  = M_AXI_BRESP;
          state_d = ST_RSP;
        end
      end
      ST_RD_AR: begin
        if (ar_hs) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        if (r_hs) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  axi_lite_watchdog #(
    .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (M_AXI_ACLK),
    .rst         (M_AXI_ARESET),
    .en          (is_wait_state(state_q)),
    .clr         (aw_hs || w_hs || b_hs || ar_hs || r_hs),
    .timeout_err (timeout_err)
  );

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboard bench for axi_lite_cmd_master with a small register-file slave
// whose per-channel stalls and read response can be steered by the stimulus.
module tb_axi_lite_cmd_master;
  import axi_lite_cmd_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        s_awready = 1'b0, s_wready = 1'b0, s_arready = 1'b0;
  logic        s_bvalid = 1'b0, s_rvalid = 1'b0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;
  logic        busy, timeout_err;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_TIMEOUT_CYCLES   (TO)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (s_awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (s_wready),
    .M_AXI_BRESP   (s_bresp),
    .M_AXI_BVALID  (s_bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (s_arready),
    .M_AXI_RDATA   (s_rdata),
    .M_AXI_RRESP   (s_rresp),
    .M_AXI_RVALID  (s_rvalid),
    .M_AXI_RREADY  (rready),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rsp_cnt  = 0;
  int   b_cnt    = 0;

  // slave steering and observation
  int          aw_stall = 0, w_stall = 0, ar_stall = 0;
  logic        b_hold = 1'b0, force_r = 1'b0;
  logic [31:0] force_rdata = '0;
  logic [1:0]  force_rresp = 2'b00;
  int          ncyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, w_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: compares every rsp handshake against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got response with no pending command");
        end else begin
          e = sb_q.pop_front();
          check("rsp_write", 32'(rsp_write), 32'(e.w));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp",  32'(rsp_resp), 32'(e.resp));
        end
        rsp_cnt++;
      end
    end
  end

  // Register-file slave: decides READY/VALID at negedge from stable master outputs.
  initial begin : slave
    logic [31:0] mem [4];
    logic [31:0] lat_awaddr, lat_wdata, lat_araddr, first_awaddr, first_wdata;
    logic [3:0]  lat_wstrb;
    logic        got_aw, got_w, prev_bready, prev_rready;
    int          aw_wait, w_wait, ar_wait;
    got_aw = 1'b0; got_w = 1'b0; prev_bready = 1'b0; prev_rready = 1'b0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    lat_awaddr = '0; lat_wdata = '0; lat_araddr = '0; lat_wstrb = '0;
    first_awaddr = '0; first_wdata = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
        s_bvalid = 1'b0; s_rvalid = 1'b0; s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
        got_aw = 1'b0; got_w = 1'b0; prev_bready = 1'b0; prev_rready = 1'b0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
      end else begin
        if (s_bvalid && prev_bready) begin s_bvalid = 1'b0; b_cnt++; end
        if (s_rvalid && prev_rready) s_rvalid = 1'b0;
        if (s_awready) begin got_aw = 1'b1; aw_hs_cyc = ncyc; end
        if (s_wready)  begin got_w  = 1'b1; w_hs_cyc  = ncyc; end
        if (s_arready) begin
          s_rvalid = 1'b1;
          s_rdata  = force_r ? force_rdata : mem[lat_araddr[3:2]];
          s_rresp  = force_r ? force_rresp : RESP_OKAY;
        end
        if (got_aw && got_w && !b_hold && !s_bvalid) begin
          for (int i = 0; i < 4; i++)
            if (lat_wstrb[i]) mem[lat_awaddr[3:2]][8*i +: 8] = lat_wdata[8*i +: 8];
          s_bvalid = 1'b1; s_bresp = RESP_OKAY; got_aw = 1'b0; got_w = 1'b0;
        end
        s_awready = 1'b0;
        if (awvalid) begin
          if (aw_wait == 0) first_awaddr = awaddr;
          if (aw_wait < aw_stall) aw_wait++;
          else begin
            s_awready = 1'b1; lat_awaddr = awaddr;
            check("awaddr_stable", awaddr, first_awaddr);
          end
        end else aw_wait = 0;
        s_wready = 1'b0;
        if (wvalid) begin
          w_hi++;
          if (w_wait == 0) first_wdata = wdata;
          if (w_wait < w_stall) w_wait++;
          else begin
            s_wready = 1'b1; lat_wdata = wdata; lat_wstrb = wstrb;
            check("wdata_stable", wdata, first_wdata);
          end
        end else w_wait = 0;
        s_arready = 1'b0;
        if (arvalid) begin
          if (ar_wait < ar_stall) ar_wait++;
          else begin s_arready = 1'b1; lat_araddr = araddr; end
        end else ar_wait = 0;
        prev_bready = bready;
        prev_rready = rready;
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp);
    exp_t e;
    int   t;
    e.w = w; e.rdata = er; e.resp = eresp;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, t);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w_hi = 0;
  endtask

  task automatic wait_rsp(input int n0);
    int t;
    t = 0;
    while (rsp_cnt == n0 && t < 300) begin @(negedge clk); t++; end
    if (rsp_cnt == n0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_wait: no response after %0d cycles, required one", t);
    end
    @(posedge clk); #1;
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp);
    int n0;
    n0 = rsp_cnt;
    send_cmd(w, a, d, s, er, eresp);
    wait_rsp(n0);
  endtask

  task automatic txn_lat(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input string name);
    int n0, lat;
    n0 = rsp_cnt;
    send_cmd(w, a, d, 4'hF, er, RESP_OKAY);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    check(name, 32'(lat), 32'd3);
    wait_rsp(n0);
  endtask

  initial begin : stim
    logic [31:0] addrs [4];
    logic [31:0] datas [4];
    logic [31:0] snap_data;
    logic [1:0]  snap_resp;
    int          b0, bad, n0, t;
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
    datas = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_handshakes", 32'({awvalid, wvalid, bready, arvalid, rready, cmd_ready}), 32'd0);
    check("rst_status", 32'({rsp_valid, busy, timeout_err}), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
    check("idle_outputs", 32'({rsp_valid, rsp_write, rsp_resp, busy, timeout_err, awprot, arprot}), 32'd0);
    check("idle_rdata", rsp_rdata, 32'd0);

    for (int i = 0; i < 4; i++) begin
      b0 = b_cnt;
      txn_lat(1'b1, addrs[i], datas[i], 32'd0, "write_latency");
      check("one_b_per_write", 32'(b_cnt - b0), 32'd1);
      txn_lat(1'b0, addrs[i], 32'd0, datas[i], "read_latency");
    end

    txn(1'b1, 32'h8, 32'h000000AA, 4'b0001, 32'd0, RESP_OKAY);
    txn(1'b0, 32'h8, 32'd0, 4'h0, 32'hDEAD00AA, RESP_OKAY);

    w_stall = 5; b0 = b_cnt;
    txn(1'b1, 32'h4, 32'h11112222, 4'hF, 32'd0, RESP_OKAY);
    check("aw_before_w", 32'(aw_hs_cyc < w_hs_cyc), 32'd1);
    check("wvalid_held", 32'(w_hi), 32'd6);
    check("one_b_w_stall", 32'(b_cnt - b0), 32'd1);
    w_stall = 0; aw_stall = 5; b0 = b_cnt;
    txn(1'b1, 32'h8, 32'h33334444, 4'hF, 32'd0, RESP_OKAY);
    check("w_before_aw", 32'(w_hs_cyc < aw_hs_cyc), 32'd1);
    check("one_b_aw_stall", 32'(b_cnt - b0), 32'd1);
    aw_stall = 0;
    txn(1'b0, 32'h4, 32'd0, 4'h0, 32'h11112222, RESP_OKAY);
    txn(1'b0, 32'h8, 32'd0, 4'h0, 32'h33334444, RESP_OKAY);

    force_r = 1'b1; force_rdata = 32'h12345678; force_rresp = RESP_SLVERR;
    txn(1'b0, 32'h0, 32'd0, 4'h0, 32'h12345678, RESP_SLVERR);
    force_r = 1'b0;
    check("slverr_no_timeout", 32'(timeout_err), 32'd0);

    rsp_ready = 1'b0; n0 = rsp_cnt;
    send_cmd(1'b0, 32'hC, 32'd0, 4'h0, 32'hBEEF0011, RESP_OKAY);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    check("rsp_valid_reached", 32'(rsp_valid), 32'd1);
    snap_data = rsp_rdata; snap_resp = rsp_resp; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_rdata !== snap_data || rsp_resp !== snap_resp) bad++;
    end
    check("rsp_hold_stable", 32'(bad), 32'd0);
    @(posedge clk); #1;
    sb_q.push_back('{1'b1, 32'd0, RESP_OKAY});
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0;
    cmd_wdata = 32'h5A5A5A5A; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    check("cmd_ready_after_rsp", 32'({cmd_ready, rsp_valid}), 32'b10);
    @(posedge clk); #1;
    check("next_cmd_accepted", 32'({busy, cmd_ready}), 32'b10);
    cmd_valid = 1'b0;
    wait_rsp(n0 + 1);

    ar_stall = 20; n0 = rsp_cnt;
    send_cmd(1'b0, 32'h0, 32'd0, 4'h0, 32'h5A5A5A5A, RESP_OKAY);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 16) check("timeout_before_limit", 32'(timeout_err), 32'd0);
      if (i == 17) check("timeout_at_limit", 32'(timeout_err), 32'd1);
    end
    wait_rsp(n0);
    ar_stall = 0;
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    txn(1'b0, 32'h4, 32'd0, 4'h0, 32'h11112222, RESP_OKAY);
    check("timeout_still_set", 32'(timeout_err), 32'd1);

    b_hold = 1'b1;
    send_cmd(1'b1, 32'h0, 32'hFFFF0000, 4'hF, 32'd0, RESP_OKAY);
    t = 0;
    while (!bready && t < 50) begin @(negedge clk); t++; end
    check("reached_wr_b", 32'(bready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_handshakes", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    check("midrst_status", 32'({busy, cmd_ready, timeout_err}), 32'd0);
    sb_q.delete();
    b_hold = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    check("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);
    txn(1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 32'd0, RESP_OKAY);
    txn(1'b0, 32'h4, 32'd0, 4'h0, 32'hCAFEF00D, RESP_OKAY);
    txn(1'b0, 32'h0, 32'd0, 4'h0, 32'h0, RESP_OKAY);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
